dcache_2way_top: RTL and testbench

Parametrised two-way set-associative write-back, write-allocate L1 data cache. It is the successor of the direct-mapped data cache and sits in the same place: between the CPU MEM stage (p1_* port) and the line-wide data memory (mem_* port). It adds configurable line width and set count, true-LRU replacement per set, word-select on the low offset bits, and saturating hit/miss performance counters.

---
 rtl/dcache_pkg.sv | 44 ++++
 rtl/dcache_way_array.sv | 70 +++++++
 rtl/dcache_2way_top.sv | 172 +++++++++++++++++
 tb/tb_dcache_2way_top.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the two-way set-associative data cache.
package dcache_pkg;

    // Controller states; the cache only accepts new requests in S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_REFILL     = 3'd3,
        S_REFILLDONE = 3'd4
    } state_e;

    // Widest supported line; word helpers operate on a line zero-extended to this.
    localparam int MAX_LINE_W = 1024;
    // Word index width covering MAX_LINE_W / 32 words.
    localparam int WSEL_W     = 5;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int line_w, input int sets);
        return 32 - idx_w(sets) - off_w(line_w);
    endfunction

    // Pick 32-bit word number wsel out of a (zero-extended) line.
    function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                             input logic [WSEL_W-1:0]     wsel);
        return line[{wsel, 5'b00000} +: 32];
    endfunction

    // Word slot 'slot' of a line after a store of new_word to word wsel.
    function automatic logic [31:0] word_merge(input logic [31:0]       old_word,
                                               input logic [31:0]       new_word,
                                               input logic [WSEL_W-1:0] wsel,
                                               input logic [WSEL_W-1:0] slot);
        return (wsel == slot) ? new_word : old_word;
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: valid/dirty/tag/line arrays with combinational read.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int IDX_W  = idx_w(SETS),
    parameter int TAG_W  = tag_w(LINE_W, SETS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              fill_en_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              word_en_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [31:0]       word_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o
);

    localparam int WORDS = LINE_W / 32;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];
    logic [LINE_W-1:0] merged;

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];

    // Current line with the store word substituted into its slot.
    always_comb begin
        merged = '0;
        for (int k = 0; k < WORDS; k++) begin
            merged[k*32 +: 32] = word_merge(line_q[idx_i][k*32 +: 32], word_i,
                                            word_sel_i, WSEL_W'(k));
        end
    end

    // Status bits: cleared by reset, set by a refill, dirtied by a store.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            line_q[idx_i] <= fill_line_i;
        end else if (word_en_i) begin
            line_q[idx_i] <= merged;
        end
    end

endmodule

// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back, write-allocate L1 data cache.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [31:0]       p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W = off_w(LINE_W);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(LINE_W, SETS);

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WSEL_W-1:0]     req_wsel;
    logic                  req, hit, new_victim;
    logic [1:0]            hit_way, fill_en, word_en, way_valid, way_dirty;
    logic [TAG_W-1:0]      way_tag  [2];
    logic [LINE_W-1:0]     way_line [2];
    logic [MAX_LINE_W-1:0] hit_line_ext;
    logic                  addr_unused;

    state_e                state_q;
    logic                  victim_q, replay_q, mem_enable_q, mem_write_q;
    logic [SETS-1:0]       lru_q;
    logic [31:0]           hit_cnt_q, miss_cnt_q;

    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag     = p1_addr_i[31:IDX_W+OFF_W];
    assign req_idx     = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign addr_unused = ^p1_addr_i[1:0];

    // Tag compare, way write enables and victim choice for the current request.
    always_comb begin
        req_wsel = '0;
        req_wsel[OFF_W-3:0] = p1_addr_i[OFF_W-1:2];
        for (int w = 0; w < 2; w++) begin
            hit_way[w] = req & way_valid[w] & (way_tag[w] == req_tag);
            fill_en[w] = (state_q == S_REFILL) & mem_ack_i & (victim_q == 1'(w));
            word_en[w] = (state_q == S_IDLE) & p1_MemWrite_i & hit_way[w];
        end
        hit = |hit_way;
        if (!way_valid[0])      new_victim = 1'b0;
        else if (!way_valid[1]) new_victim = 1'b1;
        else                    new_victim = lru_q[req_idx];
    end

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way_array #(
            .LINE_W (LINE_W),
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .idx_i       (req_idx),
            .fill_en_i   (fill_en[w]),
            .fill_tag_i  (req_tag),
            .fill_line_i (mem_data_i),
            .word_en_i   (word_en[w]),
            .word_sel_i  (req_wsel),
            .word_i      (p1_data_i),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w])
        );
    end

    // Load data comes straight from the hit way; zero when nothing hits.
    always_comb begin
        hit_line_ext = '0;
        hit_line_ext[LINE_W-1:0] = hit_way[1] ? way_line[1] : way_line[0];
        p1_data_o = hit ? word_sel(hit_line_ext, req_wsel) : 32'd0;
    end

    // Outside IDLE the CPU is held even if the lookup would already hit.
    assign p1_stall_o   = req & (~hit | (state_q != S_IDLE));
    assign mem_addr_o   = {((state_q == S_WRITEBACK) ? way_tag[victim_q] : req_tag),
                           req_idx, {OFF_W{1'b0}}};
    assign mem_data_o   = way_line[victim_q];
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // Miss handling sequence with registered memory-side strobes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            replay_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            replay_q <= (state_q == S_REFILLDONE);
            case (state_q)
                S_IDLE: begin
                    if (req && !hit) begin
                        state_q  <= S_MISS;
                        victim_q <= new_victim;
                    end
                end
                S_MISS: begin
                    mem_enable_q <= 1'b1;
                    if (way_valid[victim_q] && way_dirty[victim_q]) begin
                        state_q     <= S_WRITEBACK;
                        mem_write_q <= 1'b1;
                    end else begin
                        state_q     <= S_REFILL;
                        mem_write_q <= 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_q <= 1'b0;
                        state_q     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        mem_enable_q <= 1'b0;
                        state_q      <= S_REFILLDONE;
                    end
                end
                S_REFILLDONE: state_q <= S_IDLE;
                default:      state_q <= S_IDLE;
            endcase
        end
    end

    // A hit makes the other way of the set least-recently-used.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lru_q <= '0;
        end else if ((state_q == S_IDLE) && hit) begin
            lru_q[req_idx] <= hit_way[0];
        end
    end

    // Saturating counters; the replay after a refill is not a new hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (hit && !replay_q && (hit_cnt_q != 32'hFFFF_FFFF))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (req && !hit && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top with a line-wide memory responder.
module tb_dcache_2way_top;

    localparam int LINE_W  = 256;
    localparam int ACK_LAT = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_o;
    logic [31:0]       mem_addr_o;
    logic              mem_enable_o, mem_write_o;
    logic [31:0]       p1_data_i = '0;
    logic [31:0]       p1_addr_i = '0;
    logic              p1_MemRead_i = 1'b0;
    logic              p1_MemWrite_i = 1'b0;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [31:0]       hit_cnt_o, miss_cnt_o;

    int total = 0;
    int bad   = 0;

    logic [31:0]       exp_q[$];
    logic [31:0]       wb_addr_q[$];
    logic [LINE_W-1:0] wb_data_q[$];
    logic [31:0]       rf_addr_q[$];
    logic [LINE_W-1:0] mem_model [logic [31:0]];
    logic [31:0]       ref_mem   [logic [31:0]];
    int                lat_cnt = 0;
    logic              wr_seen = 1'b0;

    dcache_2way_top #(.LINE_W(LINE_W), .SETS(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .p1_data_i     (p1_data_i),
        .p1_addr_i     (p1_addr_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Background memory contents: word at byte address a
    function automatic logic [31:0] gen_word(input logic [31:0] a);
        return ((a >> 9) << 16) | {29'd0, a[4:2]};
    endfunction

    function automatic logic [LINE_W-1:0] gen_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W/32; i++) l[i*32 +: 32] = gen_word(la + 32'(4*i));
        return l;
    endfunction

    // Reference view of memory as the CPU sees it
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (ref_mem.exists(k)) return ref_mem[k];
        return gen_word(k);
    endfunction

    // Memory responder: ack ACK_LAT cycles after enable, logs every transfer
    initial forever begin
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        if (mem_write_o === 1'b1) wr_seen = 1'b1;
        if (rst_i !== 1'b1 || mem_enable_o !== 1'b1) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt == ACK_LAT) begin
                lat_cnt   = 0;
                mem_ack_i = 1'b1;
                if (mem_write_o) begin
                    wb_addr_q.push_back(mem_addr_o);
                    wb_data_q.push_back(mem_data_o);
                    mem_model[mem_addr_o] = mem_data_o;
                end else begin
                    rf_addr_q.push_back(mem_addr_o);
                    mem_data_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o]
                                                              : gen_line(mem_addr_o);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_rf();
        if (rf_addr_q.size() == 0) return 32'hFFFF_FFFF;
        return rf_addr_q.pop_front();
    endfunction

    // One CPU access, called at a negedge; returns at a later negedge with req dropped
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_stall, input string tag);
        int          stalls;
        logic [31:0] exp_d;
        stalls        = 0;
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemWrite_i = wr;
        p1_MemRead_i  = ~wr;
        if (wr) ref_mem[{addr[31:2], 2'b00}] = wdata;
        else    exp_q.push_back(ref_read(addr));
        #1;
        while (p1_stall_o !== 1'b0 && stalls < 200) begin
            @(negedge clk_i);
            #1;
            stalls++;
        end
        check({tag, " stall"}, 32'(stalls), 32'(exp_stall));
        if (!wr) begin
            exp_d = exp_q.pop_front();
            check({tag, " data"}, p1_data_o, exp_d);
        end
        @(negedge clk_i);
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int                wait_cnt;
        logic [LINE_W-1:0] wb_line;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst enable", 32'(mem_enable_o), 32'd0);
        check("rst write", 32'(mem_write_o), 32'd0);
        check("rst hit_cnt", hit_cnt_o, 32'd0);
        check("rst miss_cnt", miss_cnt_o, 32'd0);
        check("rst stall", 32'(p1_stall_o), 32'd0);
        check("rst data", p1_data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // 1: cold load then hit on another word of the same line
        access(1'b0, 32'h040, 32'd0, 6, "t1 cold load");
        check("t1 refill addr", pop_rf(), 32'h040);
        check("t1 no writeback", 32'(wb_addr_q.size()), 32'd0);
        check("t1 miss_cnt", miss_cnt_o, 32'd1);
        check("t1 hit_cnt replay", hit_cnt_o, 32'd0);
        access(1'b0, 32'h05C, 32'd0, 0, "t1 hit load");
        check("t1 hit_cnt", hit_cnt_o, 32'd1);

        // 2: store miss allocates into the free way, then reads back
        access(1'b1, 32'h240, 32'hDEAD_BEEF, 6, "t2 store miss");
        check("t2 refill addr", pop_rf(), 32'h240);
        check("t2 miss_cnt", miss_cnt_o, 32'd2);
        access(1'b0, 32'h240, 32'd0, 0, "t2 load back");
        check("t2 hit_cnt", hit_cnt_o, 32'd2);

        // 3: dirty LRU victim is written back before the refill
        access(1'b0, 32'h040, 32'd0, 0, "t3 touch 040");
        access(1'b0, 32'h440, 32'd0, 6 + ACK_LAT, "t3 dirty miss");
        check("t3 wb count", 32'(wb_addr_q.size()), 32'd1);
        if (wb_addr_q.size() > 0) begin
            check("t3 wb addr", wb_addr_q.pop_front(), 32'h240);
            wb_line = wb_data_q.pop_front();
            check("t3 wb word0", wb_line[31:0], 32'hDEAD_BEEF);
        end
        check("t3 refill addr", pop_rf(), 32'h440);
        check("t3 miss_cnt", miss_cnt_o, 32'd3);
        check("t3 hit_cnt", hit_cnt_o, 32'd3);

        // 4: clean victim, no write-back; refill returns the written-back data
        wr_seen = 1'b0;
        access(1'b0, 32'h240, 32'd0, 6, "t4 clean miss");
        check("t4 write never", 32'(wr_seen), 32'd0);
        check("t4 wb count", 32'(wb_addr_q.size()), 32'd0);
        check("t4 refill addr", pop_rf(), 32'h240);
        check("t4 miss_cnt", miss_cnt_o, 32'd4);

        // 5: dirty a line, force its eviction, reset during write-back
        access(1'b1, 32'h244, 32'h55AA_55AA, 0, "t5 store hit");
        access(1'b0, 32'h244, 32'd0, 0, "t5 load word1");
        access(1'b0, 32'h440, 32'd0, 0, "t5 touch 440");
        p1_addr_i    = 32'h040;
        p1_MemRead_i = 1'b1;
        wait_cnt     = 0;
        do begin
            @(negedge clk_i);
            #1;
            wait_cnt++;
        end while (mem_write_o !== 1'b1 && wait_cnt < 50);
        check("t5 reached writeback", 32'(mem_write_o), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("t5 async enable", 32'(mem_enable_o), 32'd0);
        check("t5 async write", 32'(mem_write_o), 32'd0);
        check("t5 rst miss_cnt", miss_cnt_o, 32'd0);
        check("t5 rst hit_cnt", hit_cnt_o, 32'd0);
        p1_MemRead_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        check("t5 aborted wb", 32'(wb_addr_q.size()), 32'd0);
        rf_addr_q.delete();
        @(negedge clk_i);
        access(1'b0, 32'h040, 32'd0, 6, "t5 load after reset");
        check("t5 refill addr", pop_rf(), 32'h040);
        check("t5 miss_cnt after", miss_cnt_o, 32'd1);
        check("t5 hit_cnt after", hit_cnt_o, 32'd0);

        // 6: miss counter saturates
        #1;
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.miss_cnt_q;
        @(negedge clk_i);
        check("t6 preload", miss_cnt_o, 32'hFFFF_FFFE);
        access(1'b0, 32'h1000, 32'd0, 6, "t6 miss a");
        check("t6 miss_cnt top", miss_cnt_o, 32'hFFFF_FFFF);
        access(1'b0, 32'h2000, 32'd0, 6, "t6 miss b");
        access(1'b0, 32'h3000, 32'd0, 6, "t6 miss c");
        check("t6 miss_cnt sat", miss_cnt_o, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
